// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART serializer start/busy handshake.
// The arbiter connects through the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_ready;
    logic [7:0]              tx_data;
    logic                    tx_start;
    logic                    tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one UART TX serializer.
// Enforces an idle gap after each byte and force-releases stalled locks.
module uart_tx_arbiter #(
    parameter int  NUM_REQ      = 4,
    parameter int  GAP_CLKS     = 16,
    parameter int  LOCK_TIMEOUT = 4096,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic               grant_active,
    output logic [IDW-1:0]     grant_id,
    output logic               lock_timeout
);
    localparam int GW = $clog2(GAP_CLKS + 2);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, GAP} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW:0]   cand;
    logic           hit;
    logic           last_r;
    logic           start_first;
    logic           byte_done;
    logic [7:0]     tx_data_r;
    logic [GW-1:0]  gap_cnt;
    logic [TW-1:0]  to_cnt;

    // Scan downward in offset so the smallest offset from rr_ptr wins.
    always_comb begin
        hit  = 1'b0;
        pick = rr_ptr;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ))
                cand = cand - (IDW+1)'(NUM_REQ);
            if (bus.req_valid[cand[IDW-1:0]]) begin
                hit  = 1'b1;
                pick = cand[IDW-1:0];
            end
        end
    end

    assign nxt_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        bus.req_ready = '0;
        if (state == LOAD)
            bus.req_ready[grant_id] = 1'b1;
    end

    // First START cycle always strobes; afterwards strobe only until busy shows.
    assign bus.tx_start = (state == START) && (start_first || !bus.tx_busy);
    assign bus.tx_data  = tx_data_r;

    assign byte_done = (state == BUSY && !bus.tx_busy && GAP_CLKS == 0) ||
                       (state == GAP && gap_cnt == GW'(GAP_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            lock_timeout <= 1'b0;
            tx_data_r    <= 8'h00;
            last_r       <= 1'b0;
            start_first  <= 1'b0;
            gap_cnt      <= '0;
            to_cnt       <= '0;
        end else begin
            lock_timeout <= 1'b0;
            start_first  <= 1'b0;
            case (state)
                IDLE: if (hit) begin
                    grant_id     <= pick;
                    grant_active <= 1'b1;
                    state        <= LOAD;
                end
                LOAD: if (bus.req_valid[grant_id]) begin
                    tx_data_r   <= bus.req_data[grant_id];
                    last_r      <= bus.req_last[grant_id];
                    to_cnt      <= '0;
                    start_first <= 1'b1;
                    state       <= START;
                end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                    to_cnt       <= '0;
                    lock_timeout <= 1'b1;
                    grant_active <= 1'b0;
                    rr_ptr       <= nxt_ptr;
                    state        <= IDLE;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
                START: if (bus.tx_busy) state <= BUSY;
                BUSY:  if (!bus.tx_busy) state <= GAP;
                GAP:   gap_cnt <= gap_cnt + GW'(1);
                default: state <= IDLE;
            endcase
            // Post-gap decision overrides the per-state next values above.
            if (byte_done) begin
                gap_cnt <= '0;
                if (last_r) begin
                    grant_active <= 1'b0;
                    rr_ptr       <= nxt_ptr;
                    state        <= IDLE;
                end else begin
                    state <= LOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench: dut_a (gap 16, timeout 64) with a queue-driven source and serializer model,
// dut_b (gap 0) driven cycle by cycle for the busy-already-high case.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int GAP_A = 16;
    localparam int TO    = 64;

    typedef struct {logic [7:0] d; logic l;} src_t;
    typedef struct {logic [1:0] id; logic [7:0] d;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) ifa ();
    uart_tx_arbiter_if #(.NUM_REQ(N)) ifb ();
    logic       ga_a, lt_a, ga_b, lt_b;
    logic [1:0] gid_a, gid_b;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(GAP_A), .LOCK_TIMEOUT(TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
        .grant_active(ga_a), .grant_id(gid_a), .lock_timeout(lt_a));

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(0), .LOCK_TIMEOUT(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
        .grant_active(ga_b), .grant_id(gid_b), .lock_timeout(lt_b));

    int   n_chk = 0, n_fail = 0, cyc = 0, n_to = 0, busy_len = 4, a_left = 0;
    src_t src_q[N][$];
    exp_t exp_a[$], exp_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int src_pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size();
        return s;
    endfunction

    always @(posedge clk) cyc++;

    // Requester sources: present queue heads, pop on accepted handshake.
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (rst_n && ifa.req_valid[i] && ifa.req_ready[i] && src_q[i].size() != 0)
                void'(src_q[i].pop_front());

    always @(negedge clk)
        for (int i = 0; i < N; i++) begin
            ifa.req_valid[i] = src_q[i].size() != 0;
            ifa.req_data[i]  = (src_q[i].size() != 0) ? src_q[i][0].d : 8'h00;
            ifa.req_last[i]  = (src_q[i].size() != 0) ? src_q[i][0].l : 1'b0;
        end

    // Serializer model: busy rises the cycle after tx_start, lasts busy_len cycles.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ifa.tx_busy <= 1'b0;
            a_left      <= 0;
        end else if (ifa.tx_busy) begin
            a_left <= a_left - 1;
            if (a_left == 1) ifa.tx_busy <= 1'b0;
        end else if (ifa.tx_start) begin
            ifa.tx_busy <= 1'b1;
            a_left      <= busy_len;
        end

    // Monitor A: scoreboard pop on each start, plus gap / timeout timing.
    logic         a_st_q, a_bz_q, a_ga_q;
    logic [N-1:0] a_rd_q;
    int           a_w, a_fall, a_rdy;
    exp_t         ea;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_st_q = 1'b0; a_bz_q = 1'b0; a_ga_q = 1'b0; a_rd_q = '0; a_w = 0;
        end else begin
            if (ifa.tx_start) a_w++;
            if (ifa.tx_start && !a_st_q) begin
                chk("a_start_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    ea = exp_a.pop_front();
                    chk("a_grant_id", gid_a, ea.id);
                    chk("a_tx_data", ifa.tx_data, ea.d);
                end
            end
            if (!ifa.tx_start && a_st_q) begin
                chk("a_start_width", a_w, 1);
                a_w = 0;
            end
            if (!ifa.tx_busy && a_bz_q) a_fall = cyc;
            if (ifa.req_ready != '0 && a_rd_q == '0) begin
                chk("a_ready_onehot", $countones(ifa.req_ready), 1);
                if (a_ga_q) chk("a_byte_spacing", cyc - a_fall, GAP_A + 1);
                a_rdy = cyc;
            end
            if (lt_a) begin
                n_to++;
                chk("a_timeout_delay", cyc - a_rdy, TO);
                chk("a_timeout_release", ga_a, 0);
            end else if (!ga_a && a_ga_q) begin
                chk("a_release_delay", cyc - a_fall, GAP_A + 1);
            end
            a_st_q = ifa.tx_start; a_bz_q = ifa.tx_busy; a_ga_q = ga_a; a_rd_q = ifa.req_ready;
        end
    end

    // Monitor B: scoreboard pop and strobe width.
    logic b_st_q;
    int   b_w;
    exp_t eb;
    always @(negedge clk) begin
        if (!rst_n) begin
            b_st_q = 1'b0; b_w = 0;
        end else begin
            if (ifb.tx_start) b_w++;
            if (ifb.tx_start && !b_st_q) begin
                chk("b_start_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    eb = exp_b.pop_front();
                    chk("b_grant_id", gid_b, eb.id);
                    chk("b_tx_data", ifb.tx_data, eb.d);
                end
            end
            if (!ifb.tx_start && b_st_q) begin
                chk("b_start_width", b_w, 1);
                b_w = 0;
            end
            b_st_q = ifb.tx_start;
        end
    end

    task automatic drain_a(input string name, input int budget);
        int n = 0;
        while ((exp_a.size() != 0 || src_pending() != 0 || ga_a || ifa.tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l, input logic scored);
        src_q[id].push_back('{d, l});
        if (scored) exp_a.push_back('{2'(id), d});
    endtask

    initial begin
        int n;
        ifb.req_valid = '0; ifb.req_data = '0; ifb.req_last = '0; ifb.tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", ifa.tx_start, 0);
        chk("rst_req_ready", ifa.req_ready, 0);
        chk("rst_tx_data", ifa.tx_data, 0);
        chk("rst_grant_active", ga_a, 0);
        chk("rst_grant_id", gid_a, 0);
        chk("rst_lock_timeout", lt_a, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single byte from requester 2 with a long frame.
        busy_len = 160;
        push(2, 8'hA5, 1'b1, 1'b1);
        drain_a("t1_drain", 400);
        // rr_ptr must now be 3: requester 3 beats requester 0.
        busy_len = 4;
        push(0, 8'hB0, 1'b1, 1'b0); push(3, 8'hB3, 1'b1, 1'b0);
        exp_a.push_back('{2'd3, 8'hB3}); exp_a.push_back('{2'd0, 8'hB0});
        drain_a("t1b_drain", 200);

        // All four continuously valid from rr_ptr 0.
        pulse_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b1, 1'b1);
        drain_a("t2_drain", 600);

        // Requester 1 three-byte packet not interleaved with requester 0.
        push(0, 8'h20, 1'b1, 1'b0); push(0, 8'h21, 1'b1, 1'b0);
        push(1, 8'h01, 1'b0, 1'b0); push(1, 8'h02, 1'b0, 1'b0); push(1, 8'h03, 1'b1, 1'b0);
        exp_a.push_back('{2'd0, 8'h20}); exp_a.push_back('{2'd1, 8'h01});
        exp_a.push_back('{2'd1, 8'h02}); exp_a.push_back('{2'd1, 8'h03});
        exp_a.push_back('{2'd0, 8'h21});
        drain_a("t3_drain", 400);

        // Requester 3 stalls mid-packet; lock times out, requester 0 follows.
        push(3, 8'h33, 1'b0, 1'b0); push(0, 8'h40, 1'b1, 1'b0);
        exp_a.push_back('{2'd3, 8'h33}); exp_a.push_back('{2'd0, 8'h40});
        drain_a("t4_drain", 400);
        chk("t4_timeout_count", n_to, 1);

        // Reset while the serializer is busy.
        busy_len = 20;
        push(1, 8'h55, 1'b1, 1'b1);
        n = 0;
        while (!ifa.tx_busy && n < 100) begin @(negedge clk); n++; end
        chk("t5_busy_seen", ifa.tx_busy, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("t5_tx_start", ifa.tx_start, 0);
        chk("t5_req_ready", ifa.req_ready, 0);
        chk("t5_grant_active", ga_a, 0);
        chk("t5_grant_id", gid_a, 0);
        chk("t5_tx_data", ifa.tx_data, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        busy_len = 4;
        repeat (5) @(negedge clk);
        push(2, 8'h62, 1'b1, 1'b0); push(0, 8'h60, 1'b1, 1'b0);
        exp_a.push_back('{2'd0, 8'h60}); exp_a.push_back('{2'd2, 8'h62});
        drain_a("t5_drain", 200);

        // Gap 0 with busy already high when START is entered.
        @(negedge clk);
        ifb.req_data[0] = 8'h77; ifb.req_last[0] = 1'b0; ifb.req_valid[0] = 1'b1;
        exp_b.push_back('{2'd0, 8'h77});
        @(negedge clk);
        chk("t6_ready_latency", ifb.req_ready, 4'b0001);
        chk("t6_grant_active", ga_b, 1);
        ifb.tx_busy = 1'b1;
        @(negedge clk);
        ifb.req_valid[0] = 1'b0;
        chk("t6_start_latency", ifb.tx_start, 1);
        @(negedge clk);
        chk("t6_start_one_cycle", ifb.tx_start, 0);
        repeat (2) @(negedge clk);
        ifb.tx_busy = 1'b0;
        ifb.req_data[0] = 8'h78; ifb.req_last[0] = 1'b1; ifb.req_valid[0] = 1'b1;
        exp_b.push_back('{2'd0, 8'h78});
        @(negedge clk);
        chk("t6_next_ready", ifb.req_ready, 4'b0001);
        @(negedge clk);
        chk("t6_second_start", ifb.tx_start, 1);
        @(posedge clk); #1 ifb.tx_busy = 1'b1; ifb.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t6_second_one_cycle", ifb.tx_start, 0);
        @(negedge clk);
        ifb.tx_busy = 1'b0;
        @(negedge clk);
        chk("t6_release", ga_b, 0);
        repeat (3) @(negedge clk);

        chk("end_a_queue", exp_a.size(), 0);
        chk("end_b_queue", exp_b.size(), 0);
        chk("end_timeouts", n_to, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1);
    end
endmodule
